// File: rtl/mem_arb_if.sv
// ---------------------------------------------------------------------------
// mem_arb_if
//   Bus bundle between the two requesters, the arbiter and the shared
//   bit-masked memory. The arbiter uses the 'slave' modport; the requester and
//   memory side, which is a testbench or the surrounding system, uses 'master'.
//
//   Requester side:
//     req_valid[1:0]        request pending, one bit per requester
//     req_ready[1:0]        request accepted this cycle (one-hot or zero)
//     req_wr[1:0]           1 = masked write, 0 = read
//     req_addr0/1           request address
//     req_wdata0/1          write data
//     req_mask0/1           write bit mask, 1 = bit written
//     rsp_valid[1:0]        one-cycle read-data pulse per requester
//     rsp_rdata             shared read data, qualified by rsp_valid
//   Memory side:
//     c_en, wr              access enable and write strobe
//     addr, wr_data         memory address and write data
//     bit_mask              memory write mask
//     rd_data               memory read data, valid one cycle after a read issue
// ---------------------------------------------------------------------------
interface mem_arb_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_wr;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [DATA_W-1:0] req_wdata0;
  logic [DATA_W-1:0] req_wdata1;
  logic [DATA_W-1:0] req_mask0;
  logic [DATA_W-1:0] req_mask1;
  logic [1:0]        rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              c_en;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] bit_mask;
  logic [DATA_W-1:0] rd_data;

  modport slave (
    input  req_valid, req_wr, req_addr0, req_addr1,
           req_wdata0, req_wdata1, req_mask0, req_mask1, rd_data,
    output req_ready, rsp_valid, rsp_rdata,
           c_en, wr, addr, wr_data, bit_mask
  );

  modport master (
    output req_valid, req_wr, req_addr0, req_addr1,
           req_wdata0, req_wdata1, req_mask0, req_mask1, rd_data,
    input  req_ready, rsp_valid, rsp_rdata,
           c_en, wr, addr, wr_data, bit_mask
  );
endinterface

// File: rtl/mem_arb.sv
// ---------------------------------------------------------------------------
// mem_arb
//   Two-requester arbiter in front of a single bit-masked synchronous memory.
//   Accepts at most one request per cycle (combinational grant), registers the
//   winner's access onto the memory port in the following cycle, and returns
//   read data to the requester that issued the read one cycle after that.
//
//   Ports:
//     clk     sole clock, rising edge
//     rst_n   asynchronous active-low reset
//     bus     mem_arb_if.slave: requester handshake, response and memory port
//
//   Build option:
//     MEM_ARB_FIXED_PRIO_EN  defined   -> requester 0 always wins ties (no
//                                         priority pointer, requester 1 can
//                                         starve)
//                            undefined -> round-robin tie break (default)
// ---------------------------------------------------------------------------
module mem_arb #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input logic      clk,
  input logic      rst_n,
  mem_arb_if.slave bus
);

  // -------------------------------------------------------------------------
  // Acceptance
  // -------------------------------------------------------------------------
  logic              win_id;
  logic [1:0]        grant;
  logic              xfer;
  logic              win_wr;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [DATA_W-1:0] win_mask;

`ifndef MEM_ARB_FIXED_PRIO_EN
  // Points at the requester that wins the next tie.
  logic prio_q;
  logic prio_d;
`endif

  always_comb begin
    win_id = 1'b0;
`ifdef MEM_ARB_FIXED_PRIO_EN
    if (!bus.req_valid[0]) win_id = 1'b1;
`else
    if (bus.req_valid == 2'b11) win_id = prio_q;
    else if (bus.req_valid[1]) win_id = 1'b1;
`endif
    // No grant is given while reset is asserted.
    grant = 2'b00;
    if (rst_n && (bus.req_valid != 2'b00)) grant = win_id ? 2'b10 : 2'b01;
  end

  assign xfer          = |grant;
  assign bus.req_ready = grant;

  // Only the winner's fields are ever looked at.
  assign win_wr    = bus.req_wr[win_id];
  assign win_addr  = win_id ? bus.req_addr1  : bus.req_addr0;
  assign win_wdata = win_id ? bus.req_wdata1 : bus.req_wdata0;
  assign win_mask  = win_id ? bus.req_mask1  : bus.req_mask0;

`ifndef MEM_ARB_FIXED_PRIO_EN
  // After a transfer the loser gets the next tie; otherwise hold.
  assign prio_d = xfer ? ~win_id : prio_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= 1'b0;
    else        prio_q <= prio_d;
  end
`endif

  // -------------------------------------------------------------------------
  // Issue stage: registered memory command
  // -------------------------------------------------------------------------
  logic              c_en_q,     c_en_d;
  logic              wr_q,       wr_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [DATA_W-1:0] wr_data_q,  wr_data_d;
  logic [DATA_W-1:0] bit_mask_q, bit_mask_d;
  logic              iss_id_q,   iss_id_d;

  always_comb begin
    c_en_d     = xfer;
    wr_d       = xfer & win_wr;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    bit_mask_d = bit_mask_q;
    iss_id_d   = iss_id_q;
    if (xfer) begin
      addr_d     = win_addr;
      // Reads drive zero data/mask so the memory never sees stale write data.
      wr_data_d  = win_wr ? win_wdata : '0;
      bit_mask_d = win_wr ? win_mask  : '0;
      iss_id_d   = win_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_en_q     <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wr_data_q  <= '0;
      bit_mask_q <= '0;
      iss_id_q   <= 1'b0;
    end else begin
      c_en_q     <= c_en_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      bit_mask_q <= bit_mask_d;
      iss_id_q   <= iss_id_d;
    end
  end

  assign bus.c_en     = c_en_q;
  assign bus.wr       = wr_q;
  assign bus.addr     = addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.bit_mask = bit_mask_q;

  // -------------------------------------------------------------------------
  // Response stage
  // -------------------------------------------------------------------------
  // The memory's rd_data is already a register output that becomes valid in
  // the cycle after the read issue, which is exactly the response cycle. It is
  // forwarded while a pulse is active and captured into rdata_hold_q so the
  // shared data bus is stable (and zero after reset) between responses.
  logic [1:0]        rsp_valid_q,  rsp_valid_d;
  logic [DATA_W-1:0] rdata_hold_q, rdata_hold_d;
  logic              rsp_any;

  assign rsp_any = |rsp_valid_q;

  always_comb begin
    rsp_valid_d = 2'b00;
    if (c_en_q && !wr_q) rsp_valid_d = iss_id_q ? 2'b10 : 2'b01;
    rdata_hold_d = rsp_any ? bus.rd_data : rdata_hold_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 2'b00;
      rdata_hold_q <= '0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rdata_hold_q <= rdata_hold_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_any ? bus.rd_data : rdata_hold_q;

endmodule
